ob_mc_frontend: RTL and testbench
=================================

// Module: ob_mc_frontend
// PURPOSE
//  Multi-channel command/response front end for the order-book controller.
//  CH_N independent clients each own an ingress FIFO and an egress FIFO.
//  A locking round-robin arbiter merges the ingress FIFOs into the single
//  command stream consumed by ob_cntrl, tagged with the channel id.
//  Responses carry a channel id and are routed back to that channel's egress FIFO.
// PARAMETERS
//  CH_N      4   number of client channels (>=2); CH_W = $clog2(CH_N)
//  CMD_W     64  command width (= $bits(ob_pkg::cmd_t) at instantiation)
//  RSP_W     64  response width (= $bits(ob_pkg::rsp_t) at instantiation)
//  IN_DEPTH  4   entries per ingress FIFO (power of 2, >=2)
//  OUT_DEPTH 4   entries per egress FIFO (power of 2, >=2)
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active-low (0 = reset)
//  cmd_vld_r      in   CH_N       per-channel command push
//  cmd_r          in   CH_N*CMD_W command data; channel i at [i*CMD_W +: CMD_W]
//  cmd_full_r     out  CH_N       ingress FIFO i full (registered)
//  rsp_accept     in   CH_N       client i consumes its head response
//  rsp_vld        out  CH_N       egress FIFO i non-empty (registered)
//  rsp            out  CH_N*RSP_W egress head data, same packing as cmd_r
//  cntrl_cmd_vld  out  1          merged command available
//  cntrl_cmd      out  CMD_W      merged command data
//  cntrl_cmd_ch   out  CH_W       source channel of cntrl_cmd
//  cntrl_cmd_pop  in   1          controller consumes cntrl_cmd
//  cntrl_rsp_vld  in   1          controller response push
//  cntrl_rsp      in   RSP_W      response data
//  cntrl_rsp_ch   in   CH_W       destination channel
//  cntrl_rsp_full_r out 1         back-pressure to controller (registered)
//  err_ovf_r      out  CH_N       sticky: push dropped on ingress FIFO i
// BEHAVIOUR
//  Reset: all FIFOs empty; cmd_full_r=0, rsp_vld=0, cntrl_cmd_vld=0,
//   cntrl_rsp_full_r=0, err_ovf_r=0, rr pointer=0, lock clear. Reset
//   mid-operation discards all queued entries; no output survives reset.
//  Ingress: push at cycle t is visible to arbiter at t+1 (flags registered).
//   cmd_full_r[i]=1 when occupancy after update == IN_DEPTH. Push while
//   cmd_full_r[i]=1 is dropped and sets err_ovf_r[i], even if the same
//   channel is popped that cycle. Push into empty FIFO is not poppable same cycle.
//  Arbiter states: IDLE (no lock) / LOCKED(ch).
//   IDLE: if any ingress non-empty, select first non-empty channel scanning
//    from rr_ptr upward mod CH_N; present it combinationally, enter LOCKED.
//   LOCKED(ch): cntrl_cmd/cntrl_cmd_ch held stable until cntrl_cmd_pop;
//    grant never changes while unpopped, even if higher-priority channels fill.
//   On pop: dequeue FIFO ch, rr_ptr <= (ch+1) mod CH_N, return to IDLE; the
//    next selection may be presented in the following cycle (1 cmd/cycle max).
//   cntrl_cmd_pop with cntrl_cmd_vld=0 is ignored.
//  Egress: cntrl_rsp_vld pushes cntrl_rsp into FIFO cntrl_rsp_ch; rsp_vld at t+1.
//   Pop when rsp_vld[i] & rsp_accept[i]; simultaneous push/pop on the same
//   FIFO keeps occupancy constant. cntrl_rsp_ch >= CH_N: response dropped.
//  cntrl_rsp_full_r=1 when any egress FIFO occupancy after update >=
//   OUT_DEPTH-1 (one-slot margin for the registered flag); controller must not
//   push while asserted. A push into a full egress FIFO is dropped (no error flag).
//  Pointers wrap mod depth; occupancy counters are $clog2(depth)+1 bits.
// TESTING
//  Reset: hold rst=0 3 cycles with pushes active -> all outputs 0, FIFOs empty.
//  RR fairness: CH_N=4, all 4 ingress hold 2 cmds, pop every cycle ->
//   cntrl_cmd_ch sequence 0,1,2,3,0,1,2,3.
//  Lock: ch2 granted, hold pop=0 5 cycles while ch0 fills -> cntrl_cmd_ch stays 2.
//  Overflow: push 5 cmds to ch1 with no pop (IN_DEPTH=4) -> cmd_full_r[1]
//   after 4th, 5th dropped, err_ovf_r[1]=1, subsequent pops return cmds 1..4.
//  Routing/backpressure: 3 rsps to ch3, rsp_accept=0 -> rsp_vld[3]=1,
//   cntrl_rsp_full_r=1 after 3rd (OUT_DEPTH=4); accept 1 -> full_r drops.
//  Mid-op reset: fill ch0 ingress and ch2 egress, assert rst=0 1 cycle ->
//   cntrl_cmd_vld=0, rsp_vld=0, rr_ptr=0 next cycle.

Source files
------------

// File: rtl/ob_mc_frontend.sv
// Multi-channel command/response front end: per-channel ingress FIFOs merged by a
// locking round-robin arbiter, and responses routed back into per-channel egress FIFOs.
module ob_mc_frontend #(
  parameter int CH_N      = 4,
  parameter int CMD_W     = 64,
  parameter int RSP_W     = 64,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  localparam int CH_W     = $clog2(CH_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH_N-1:0]       cmd_vld_r,
  input  logic [CH_N*CMD_W-1:0] cmd_r,
  output logic [CH_N-1:0]       cmd_full_r,
  input  logic [CH_N-1:0]       rsp_accept,
  output logic [CH_N-1:0]       rsp_vld,
  output logic [CH_N*RSP_W-1:0] rsp,
  output logic                  cntrl_cmd_vld,
  output logic [CMD_W-1:0]      cntrl_cmd,
  output logic [CH_W-1:0]       cntrl_cmd_ch,
  input  logic                  cntrl_cmd_pop,
  input  logic                  cntrl_rsp_vld,
  input  logic [RSP_W-1:0]      cntrl_rsp,
  input  logic [CH_W-1:0]       cntrl_rsp_ch,
  output logic                  cntrl_rsp_full_r,
  output logic [CH_N-1:0]       err_ovf_r,
  output logic                  dbg_locked,
  output logic [CH_W-1:0]       dbg_rr_ptr
);
  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  // Handshake: a command transfers on a cycle where cntrl_cmd_vld and cntrl_cmd_pop are
  // both high; a response transfers on a cycle where rsp_vld[i] and rsp_accept[i] are both high.

  logic [CMD_W-1:0] in_mem  [CH_N][IN_DEPTH];
  logic [IN_AW-1:0] in_wp   [CH_N];
  logic [IN_AW-1:0] in_rp   [CH_N];
  logic [IN_AW:0]   in_cnt  [CH_N];
  logic [IN_AW:0]   in_cnt_nxt [CH_N];
  logic [CH_N-1:0]  in_push, in_pop, in_ne_r;

  logic [RSP_W-1:0]  out_mem [CH_N][OUT_DEPTH];
  logic [OUT_AW-1:0] out_wp  [CH_N];
  logic [OUT_AW-1:0] out_rp  [CH_N];
  logic [OUT_AW:0]   out_cnt [CH_N];
  logic [OUT_AW:0]   out_cnt_nxt [CH_N];
  logic [CH_N-1:0]   out_push, out_pop;
  logic              out_hi;

  state_t           state, state_nxt;
  logic [CH_W-1:0]  lock_ch, lock_nxt, rr_ptr, rr_nxt, sel_ch, grant_ch;
  logic             sel_found, pop_fire;

  // Round-robin scan starting at rr_ptr over the registered non-empty flags.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int k = 0; k < CH_N; k++) begin
      if (!sel_found && in_ne_r[(int'(rr_ptr) + k) % CH_N]) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'((int'(rr_ptr) + k) % CH_N);
      end
    end
  end

  assign grant_ch      = (state == ST_LOCKED) ? lock_ch : sel_ch;
  assign cntrl_cmd_vld = (state == ST_LOCKED) | sel_found;
  assign cntrl_cmd_ch  = grant_ch;
  assign cntrl_cmd     = in_mem[grant_ch][in_rp[grant_ch]];
  assign pop_fire      = cntrl_cmd_pop & cntrl_cmd_vld;
  assign dbg_locked    = (state == ST_LOCKED);
  assign dbg_rr_ptr    = rr_ptr;

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_ch;
    rr_nxt    = rr_ptr;
    if (pop_fire) begin
      state_nxt = ST_IDLE;
      rr_nxt    = (grant_ch == CH_W'(CH_N - 1)) ? '0 : grant_ch + 1'b1;
    end else if (state == ST_IDLE && sel_found) begin
      state_nxt = ST_LOCKED;
      lock_nxt  = sel_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_nxt;
      rr_ptr  <= rr_nxt;
    end
  end

  // A push is judged against the registered full flag, so a same-cycle pop cannot rescue it.
  always_comb begin
    out_hi = 1'b0;
    for (int i = 0; i < CH_N; i++) begin
      in_push[i]     = cmd_vld_r[i] & ~cmd_full_r[i];
      in_pop[i]      = pop_fire && (grant_ch == CH_W'(i));
      in_cnt_nxt[i]  = in_cnt[i] + (IN_AW+1)'(in_push[i]) - (IN_AW+1)'(in_pop[i]);
      out_push[i]    = cntrl_rsp_vld && (cntrl_rsp_ch == CH_W'(i)) &&
                       (out_cnt[i] != (OUT_AW+1)'(OUT_DEPTH));
      out_pop[i]     = rsp_vld[i] & rsp_accept[i];
      out_cnt_nxt[i] = out_cnt[i] + (OUT_AW+1)'(out_push[i]) - (OUT_AW+1)'(out_pop[i]);
      if (out_cnt_nxt[i] >= (OUT_AW+1)'(OUT_DEPTH - 1)) out_hi = 1'b1;
      rsp[i*RSP_W +: RSP_W] = out_mem[i][out_rp[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CH_N; i++) begin
        in_wp[i]   <= '0;
        in_rp[i]   <= '0;
        in_cnt[i]  <= '0;
        out_wp[i]  <= '0;
        out_rp[i]  <= '0;
        out_cnt[i] <= '0;
      end
      cmd_full_r       <= '0;
      in_ne_r          <= '0;
      err_ovf_r        <= '0;
      rsp_vld          <= '0;
      cntrl_rsp_full_r <= 1'b0;
    end else begin
      for (int i = 0; i < CH_N; i++) begin
        if (in_push[i])  in_wp[i]  <= in_wp[i] + 1'b1;
        if (in_pop[i])   in_rp[i]  <= in_rp[i] + 1'b1;
        if (out_push[i]) out_wp[i] <= out_wp[i] + 1'b1;
        if (out_pop[i])  out_rp[i] <= out_rp[i] + 1'b1;
        in_cnt[i]     <= in_cnt_nxt[i];
        out_cnt[i]    <= out_cnt_nxt[i];
        cmd_full_r[i] <= (in_cnt_nxt[i] == (IN_AW+1)'(IN_DEPTH));
        in_ne_r[i]    <= (in_cnt_nxt[i] != '0);
        rsp_vld[i]    <= (out_cnt_nxt[i] != '0);
        err_ovf_r[i]  <= err_ovf_r[i] | (cmd_vld_r[i] & cmd_full_r[i]);
      end
      cntrl_rsp_full_r <= out_hi;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CH_N; i++) begin
      if (in_push[i])  in_mem[i][in_wp[i]]   <= cmd_r[i*CMD_W +: CMD_W];
      if (out_push[i]) out_mem[i][out_wp[i]] <= cntrl_rsp;
    end
  end
endmodule

// File: tb/tb_ob_mc_frontend.sv
// Directed bench for ob_mc_frontend: reset, round-robin order, lock hold,
// ingress overflow, response routing/back-pressure and mid-operation reset.
module tb_ob_mc_frontend;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   cmd_vld_r;
  logic [255:0] cmd_r;
  logic [3:0]   cmd_full_r;
  logic [3:0]   rsp_accept;
  logic [3:0]   rsp_vld;
  logic [255:0] rsp;
  logic         cntrl_cmd_vld;
  logic [63:0]  cntrl_cmd;
  logic [1:0]   cntrl_cmd_ch;
  logic         cntrl_cmd_pop;
  logic         cntrl_rsp_vld;
  logic [63:0]  cntrl_rsp;
  logic [1:0]   cntrl_rsp_ch;
  logic         cntrl_rsp_full_r;
  logic [3:0]   err_ovf_r;
  logic         dbg_locked;
  logic [1:0]   dbg_rr_ptr;

  int passed = 0;
  int total  = 0;

  ob_mc_frontend dut (
    .clk(clk), .rst(rst), .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r), .cmd_full_r(cmd_full_r),
    .rsp_accept(rsp_accept), .rsp_vld(rsp_vld), .rsp(rsp),
    .cntrl_cmd_vld(cntrl_cmd_vld), .cntrl_cmd(cntrl_cmd), .cntrl_cmd_ch(cntrl_cmd_ch),
    .cntrl_cmd_pop(cntrl_cmd_pop), .cntrl_rsp_vld(cntrl_rsp_vld), .cntrl_rsp(cntrl_rsp),
    .cntrl_rsp_ch(cntrl_rsp_ch), .cntrl_rsp_full_r(cntrl_rsp_full_r), .err_ovf_r(err_ovf_r),
    .dbg_locked(dbg_locked), .dbg_rr_ptr(dbg_rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0; cmd_vld_r = 4'hf; cmd_r = '0; rsp_accept = '0; cntrl_cmd_pop = 1'b0;
    cntrl_rsp_vld = 1'b1; cntrl_rsp = 64'h55; cntrl_rsp_ch = 2'd0;
    for (int i = 0; i < 4; i++) cmd_r[i*64 +: 64] = 64'h99;

    // Reset held with pushes active
    repeat (3) tick();
    chk("rst_full", 64'(cmd_full_r), 64'h0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'h0);
    chk("rst_cmd_vld", 64'(cntrl_cmd_vld), 64'h0);
    chk("rst_rsp_full", 64'(cntrl_rsp_full_r), 64'h0);
    chk("rst_err", 64'(err_ovf_r), 64'h0);
    chk("rst_rr", 64'(dbg_rr_ptr), 64'h0);
    chk("rst_lock", 64'(dbg_locked), 64'h0);
    cmd_vld_r = '0; cntrl_rsp_vld = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_rst_cmd_vld", 64'(cntrl_cmd_vld), 64'h0);

    // Round robin: two commands per channel, pop every cycle
    cmd_vld_r = 4'hf;
    for (int i = 0; i < 4; i++) cmd_r[i*64 +: 64] = 64'h10 + 64'(i);
    tick();
    for (int i = 0; i < 4; i++) cmd_r[i*64 +: 64] = 64'h20 + 64'(i);
    tick();
    cmd_vld_r = '0;
    cntrl_cmd_pop = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_vld%0d", k), 64'(cntrl_cmd_vld), 64'h1);
      chk($sformatf("rr_ch%0d", k), 64'(cntrl_cmd_ch), 64'(k % 4));
      chk($sformatf("rr_data%0d", k), cntrl_cmd, ((k < 4) ? 64'h10 : 64'h20) + 64'(k % 4));
      tick();
    end
    cntrl_cmd_pop = 1'b0;
    chk("rr_empty", 64'(cntrl_cmd_vld), 64'h0);
    chk("rr_ptr_wrap", 64'(dbg_rr_ptr), 64'h0);

    // Lock: ch2 granted, ch0 fills while pop held low
    cmd_vld_r = 4'b0100; cmd_r[2*64 +: 64] = 64'ha2;
    tick();
    cmd_vld_r = '0;
    chk("lock_first_ch", 64'(cntrl_cmd_ch), 64'h2);
    for (int j = 0; j < 5; j++) begin
      cmd_vld_r[0] = (j < 3);
      cmd_r[0 +: 64] = 64'hb0 + 64'(j);
      tick();
      chk($sformatf("lock_ch%0d", j), 64'(cntrl_cmd_ch), 64'h2);
      chk($sformatf("lock_data%0d", j), cntrl_cmd, 64'ha2);
    end
    cmd_vld_r = '0;
    chk("lock_state", 64'(dbg_locked), 64'h1);
    cntrl_cmd_pop = 1'b1;
    tick();
    chk("unlock_ch", 64'(cntrl_cmd_ch), 64'h0);
    chk("unlock_data0", cntrl_cmd, 64'hb0);
    tick();
    chk("unlock_data1", cntrl_cmd, 64'hb1);
    tick();
    chk("unlock_data2", cntrl_cmd, 64'hb2);
    tick();
    cntrl_cmd_pop = 1'b0;
    chk("unlock_empty", 64'(cntrl_cmd_vld), 64'h0);
    chk("unlock_rr", 64'(dbg_rr_ptr), 64'h1);

    // Overflow: five pushes to ch1, no pop
    for (int k = 1; k <= 5; k++) begin
      cmd_vld_r = 4'b0010; cmd_r[64 +: 64] = 64'hc0 + 64'(k);
      tick();
      chk($sformatf("ovf_full%0d", k), 64'(cmd_full_r[1]), (k >= 4) ? 64'h1 : 64'h0);
      chk($sformatf("ovf_err%0d", k), 64'(err_ovf_r), (k == 5) ? 64'h2 : 64'h0);
    end
    cmd_vld_r = '0;
    cntrl_cmd_pop = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_pop_ch%0d", k), 64'(cntrl_cmd_ch), 64'h1);
      chk($sformatf("ovf_pop_data%0d", k), cntrl_cmd, 64'hc0 + 64'(k));
      tick();
      chk($sformatf("ovf_full_after%0d", k), 64'(cmd_full_r[1]), 64'h0);
    end
    cntrl_cmd_pop = 1'b0;
    chk("ovf_empty", 64'(cntrl_cmd_vld), 64'h0);
    chk("ovf_sticky", 64'(err_ovf_r), 64'h2);

    // Response routing and back-pressure on ch3
    cntrl_rsp_ch = 2'd3;
    for (int k = 1; k <= 3; k++) begin
      cntrl_rsp_vld = 1'b1; cntrl_rsp = 64'hd0 + 64'(k);
      tick();
      chk($sformatf("rsp_vld%0d", k), 64'(rsp_vld), 64'h8);
      chk($sformatf("rsp_bp%0d", k), 64'(cntrl_rsp_full_r), (k == 3) ? 64'h1 : 64'h0);
    end
    cntrl_rsp_vld = 1'b0;
    chk("rsp_head1", rsp[3*64 +: 64], 64'hd1);
    rsp_accept = 4'b1000;
    tick();
    rsp_accept = '0;
    chk("rsp_bp_drop", 64'(cntrl_rsp_full_r), 64'h0);
    chk("rsp_head2", rsp[3*64 +: 64], 64'hd2);
    cntrl_rsp_vld = 1'b1; cntrl_rsp = 64'hd4; rsp_accept = 4'b1000;
    tick();
    cntrl_rsp_vld = 1'b0; rsp_accept = '0;
    chk("rsp_pushpop_head", rsp[3*64 +: 64], 64'hd3);
    chk("rsp_pushpop_bp", 64'(cntrl_rsp_full_r), 64'h0);

    // Mid-operation reset with ch0 ingress full and ch2 egress loaded
    cntrl_rsp_ch = 2'd2;
    for (int k = 0; k < 4; k++) begin
      cmd_vld_r = 4'b0001; cmd_r[0 +: 64] = 64'he0 + 64'(k);
      cntrl_rsp_vld = (k < 2); cntrl_rsp = 64'hf0 + 64'(k);
      tick();
    end
    cmd_vld_r = '0; cntrl_rsp_vld = 1'b0;
    chk("pre_rst_full", 64'(cmd_full_r), 64'h1);
    chk("pre_rst_rsp_vld", 64'(rsp_vld), 64'hc);
    chk("pre_rst_cmd", cntrl_cmd, 64'he0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_cmd_vld", 64'(cntrl_cmd_vld), 64'h0);
    chk("mid_rst_rsp_vld", 64'(rsp_vld), 64'h0);
    chk("mid_rst_rr", 64'(dbg_rr_ptr), 64'h0);
    chk("mid_rst_full", 64'(cmd_full_r), 64'h0);
    chk("mid_rst_err", 64'(err_ovf_r), 64'h0);
    tick();
    chk("post_mid_rst_cmd_vld", 64'(cntrl_cmd_vld), 64'h0);
    chk("post_mid_rst_rsp_vld", 64'(rsp_vld), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
